// File: rtl/hex_scan_pkg.sv
// Shared types and constants for the hex digit scan controller.
// Segment and digit-enable encodings are active-low.
package hex_scan_pkg;

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam int MAX_DIGITS = 32;
  localparam logic [MAX_DIGITS-1:0] DIG_OFF = '1;

endpackage

// File: rtl/full_display.sv
// Hex nibble to active-low 7-segment decoder, segments G..A.
// Shared by every digit of the scanned display.
module full_display (
  input  logic [3:0] in,
  output logic [6:0] out
);

  always_comb begin
    out = 7'h7F;
    unique case (in)
      4'h0: out = 7'h40;
      4'h1: out = 7'h79;
      4'h2: out = 7'h24;
      4'h3: out = 7'h30;
      4'h4: out = 7'h19;
      4'h5: out = 7'h12;
      4'h6: out = 7'h02;
      4'h7: out = 7'h78;
      4'h8: out = 7'h00;
      4'h9: out = 7'h10;
      4'hA: out = 7'h08;
      4'hB: out = 7'h03;
      4'hC: out = 7'h46;
      4'hD: out = 7'h21;
      4'hE: out = 7'h06;
      4'hF: out = 7'h0E;
      default: out = 7'h7F;
    endcase
  end

endmodule

// File: rtl/scan_timer.sv
// Phase counter and digit index for the scan controller.
// One counter is shared by the BLANK and DRIVE phases.
module scan_timer #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int GUARD      = 500,
  localparam int IW        = $clog2(NUM_DIGITS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          drive,
  output logic          tc,
  output logic [IW-1:0] idx,
  output logic          frame_done
);

  localparam int MAXP = (PRESCALE > GUARD) ? PRESCALE : GUARD;
  localparam int CW   = $clog2(MAXP) + 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] last;
  logic          idx_last;

  assign last       = drive ? CW'(PRESCALE - 1) : CW'(GUARD - 1);
  assign tc         = (cnt == last);
  assign idx_last   = (idx == IW'(NUM_DIGITS - 1));
  assign frame_done = drive & tc & idx_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tc ? '0 : cnt + 1'b1;
      if (drive && tc)
        idx <= idx_last ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/hex_scan_controller.sv
// Time-multiplexed hex display driver with a buffered load port
// and tear-free frame-boundary update.
module hex_scan_controller
  import hex_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int GUARD      = 500
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic                    blank_leading,
  output logic [3:0]              dec_in,
  input  logic [6:0]              dec_out,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int W  = 4 * NUM_DIGITS;

  state_t                state, state_nx;
  logic                  tc;
  logic [IW-1:0]         idx;
  logic [W-1:0]          disp_reg;
  logic [W-1:0]          pend_reg;
  logic                  pend_valid;
  logic                  blank_reg;
  logic                  accept;
  logic                  hide;
  logic [6:0]            seg_nx;
  logic [NUM_DIGITS-1:0] en_nx;

  scan_timer #(
    .NUM_DIGITS(NUM_DIGITS),
    .PRESCALE  (PRESCALE),
    .GUARD     (GUARD)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .drive     (state == ST_DRIVE),
    .tc        (tc),
    .idx       (idx),
    .frame_done(frame_done)
  );

  assign dec_in = disp_reg[{idx, 2'b00} +: 4];
  assign accept = load_valid & load_ready;

  // Digit 0 always shows, so a zero value still reads "0".
  assign hide = blank_reg && (idx != '0) &&
                ((disp_reg >> {idx, 2'b00}) == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_BLANK;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    seg_nx   = seg_out;
    en_nx    = digit_en;
    unique case (state)
      ST_BLANK: begin
        if (tc) begin
          state_nx = ST_DRIVE;
          seg_nx   = hide ? SEG_OFF : dec_out;
          en_nx    = ~(NUM_DIGITS'(1) << idx);
        end
      end
      ST_DRIVE: begin
        if (tc) begin
          state_nx = ST_BLANK;
          seg_nx   = SEG_OFF;
          en_nx    = DIG_OFF[NUM_DIGITS-1:0];
        end
      end
      default: state_nx = ST_BLANK;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seg_out  <= SEG_OFF;
      digit_en <= DIG_OFF[NUM_DIGITS-1:0];
    end else begin
      seg_out  <= seg_nx;
      digit_en <= en_nx;
    end
  end

  // An empty buffer at the boundary lets a same-cycle load go straight to display.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      disp_reg   <= '0;
      pend_reg   <= '0;
      pend_valid <= 1'b0;
      load_ready <= 1'b1;
      blank_reg  <= 1'b0;
    end else if (frame_done) begin
      blank_reg  <= blank_leading;
      pend_valid <= 1'b0;
      load_ready <= 1'b1;
      if (pend_valid)  disp_reg <= pend_reg;
      else if (accept) disp_reg <= load_data;
    end else if (accept) begin
      pend_reg   <= load_data;
      pend_valid <= 1'b1;
      load_ready <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hex_scan_controller.sv
// Randomized self-checking bench for hex_scan_controller
// against a frame/slot-position reference model.
module tb_hex_scan_controller;

  localparam int ND    = 4;
  localparam int PS    = 4;
  localparam int GD    = 1;
  localparam int SLOT  = GD + PS;
  localparam int FRAME = ND * SLOT;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] load_data = '0;
  logic        load_valid = 1'b0;
  logic        blank_leading = 1'b0;
  logic        load_ready;
  logic [3:0]  dec_in;
  logic [6:0]  dec_out;
  logic [6:0]  seg_out;
  logic [3:0]  digit_en;
  logic        frame_done;

  always #5 clock = ~clock;

  hex_scan_controller #(
    .NUM_DIGITS(ND),
    .PRESCALE  (PS),
    .GUARD     (GD)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .blank_leading(blank_leading),
    .dec_in       (dec_in),
    .dec_out      (dec_out),
    .seg_out      (seg_out),
    .digit_en     (digit_en),
    .frame_done   (frame_done)
  );

  full_display u_dec (
    .in (dec_in),
    .out(dec_out)
  );

  int total = 0;
  int bad   = 0;

  int          t;
  logic [15:0] disp;
  logic        blank_m;
  logic [15:0] pend_q[$];
  logic        accepted;

  logic [6:0] seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    t       = 0;
    disp    = '0;
    blank_m = 1'b0;
    pend_q.delete();
  endtask

  task automatic check_outputs();
    int          pos;
    int          slot;
    logic [3:0]  nib;
    logic [3:0]  en_exp;
    logic [15:0] above;
    logic        hide;
    pos    = t % SLOT;
    slot   = (t % FRAME) / SLOT;
    nib    = disp[4*slot +: 4];
    en_exp = ~(4'b0001 << slot);
    above  = disp >> (4 * slot);
    hide   = blank_m && (slot > 0) && (above == 16'h0);
    chk("load_ready", load_ready, pend_q.size() == 0);
    chk("frame_done", frame_done, (t % FRAME) == FRAME - 1);
    chk("dec_in", dec_in, nib);
    if (pos < GD) begin
      chk("digit_en_gap", digit_en, 4'hF);
      chk("seg_gap", seg_out, 7'h7F);
    end else begin
      chk("digit_en", digit_en, en_exp);
      chk("seg", seg_out, hide ? 7'h7F : seg_tab[nib]);
    end
  endtask

  task automatic step();
    check_outputs();
    @(posedge clock);
    accepted = load_valid && (pend_q.size() == 0);
    if ((t % FRAME) == FRAME - 1) begin
      blank_m = blank_leading;
      if (pend_q.size() > 0) disp = pend_q.pop_front();
      else if (accepted)     disp = load_data;
      pend_q.delete();
    end else if (accepted) begin
      pend_q.push_back(load_data);
    end
    t++;
    @(negedge clock);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(int ph);
    for (int i = 0; i < FRAME; i++) begin
      if ((t % FRAME) == ph) break;
      step();
    end
  endtask

  task automatic offer(logic [15:0] w);
    load_data  = w;
    load_valid = 1'b1;
    accepted   = 1'b0;
    for (int k = 0; k < 3 * FRAME; k++) begin
      step();
      if (accepted) break;
    end
    load_valid = 1'b0;
    chk("accept_timeout", accepted, 1'b1);
  endtask

  initial begin
    logic hold;
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    model_reset();

    run(2 * FRAME);

    run_to(7);
    offer(16'h1234);
    run(2 * FRAME);

    blank_leading = 1'b1;
    run_to(3);
    offer(16'h0050);
    run(2 * FRAME);

    run_to(3);
    offer(16'h0000);
    run(2 * FRAME);

    blank_leading = 1'b0;
    run_to(2);
    offer(16'hAAAA);
    offer(16'hBBBB);
    run(2 * FRAME);

    run_to(FRAME - 1);
    load_data  = 16'hCAFE;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chk("bypass_acc", accepted, 1'b1);
    chk("bypass_disp", disp, 16'hCAFE);
    run(FRAME + 2);

    hold = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!hold) begin
        load_valid = ($urandom_range(0, 3) == 0);
        load_data  = 16'($urandom);
      end
      if ($urandom_range(0, 39) == 0) blank_leading = 1'($urandom);
      step();
      hold = load_valid && !accepted;
    end
    load_valid    = 1'b0;
    blank_leading = 1'b0;

    run_to(5);
    offer(16'h7777);
    run_to(12);
    #2 reset = 1'b1;
    #1;
    chk("rst_seg", seg_out, 7'h7F);
    chk("rst_digit_en", digit_en, 4'hF);
    chk("rst_ready", load_ready, 1'b1);
    chk("rst_frame_done", frame_done, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    run(FRAME + 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
